// File: rtl/pcie_tx_arb_pkg.sv
// rtl/pcie_tx_arb_pkg.sv - shared types and constants for the PCIe TX arbiter
package pcie_tx_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XMIT = 2'd2
  } arb_state_e;

  localparam int MAX_REQ = 4;
  localparam int DATA_W  = 16;

  function automatic int clog2(input int value);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) w = i + 1;
    end
    return w;
  endfunction

  localparam int IDX_W = clog2(MAX_REQ);

endpackage

// File: rtl/pcie_tx_arbiter_rr_pick.sv
// rtl/pcie_tx_arbiter_rr_pick.sv - combinational round-robin picker
module rr_pick
  import pcie_tx_arb_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   last_i,
  output logic [NUM_REQ-1:0] win_o,
  output logic [IDX_W-1:0]   idx_o
);

  logic found;

  // Search upward from last+1 with wrap-around; first hit wins.
  always_comb begin
    win_o = '0;
    idx_o = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found && req_i[i] && (i == (int'(last_i) + k) % NUM_REQ)) begin
          found    = 1'b1;
          win_o[i] = 1'b1;
          idx_o    = IDX_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/pcie_tx_arbiter.sv
// rtl/pcie_tx_arbiter.sv - round-robin sharing of the PCIe core TX port between TLP sources
module pcie_tx_arbiter
  import pcie_tx_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT = 1024
) (
  input  logic                      clk_125,
  input  logic                      rstn,
  input  logic [NUM_REQ-1:0]        req_tx_req,
  output logic [NUM_REQ-1:0]        req_tx_rdy,
  input  logic [NUM_REQ-1:0]        req_tx_st,
  input  logic [NUM_REQ-1:0]        req_tx_end,
  input  logic [DATA_W*NUM_REQ-1:0] req_tx_data,
  output logic                      tx_req,
  input  logic                      tx_rdy,
  output logic                      tx_st,
  output logic                      tx_end,
  output logic [DATA_W-1:0]         tx_data,
  output logic [NUM_REQ-1:0]        grant,
  output logic                      pkt_timeout
);

  localparam int TW = clog2(TIMEOUT);

  arb_state_e          state_q;
  logic [NUM_REQ-1:0]  grant_q;
  logic [IDX_W-1:0]    gidx_q;
  logic [IDX_W-1:0]    last_q;
  logic [TW-1:0]       timer_q;

  logic [NUM_REQ-1:0]  win;
  logic [IDX_W-1:0]    win_idx;
  logic                st_mux;
  logic                end_mux;
  logic [DATA_W-1:0]   data_mux;
  logic                g_req;
  logic                g_end;
  logic                busy;
  logic                timeout_hit;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req_i  (req_tx_req),
    .last_i (last_q),
    .win_o  (win),
    .idx_o  (win_idx)
  );

  // Only the granted lane reaches the core; all lanes masked while idle.
  always_comb begin
    st_mux   = 1'b0;
    end_mux  = 1'b0;
    data_mux = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) begin
        st_mux   = st_mux | req_tx_st[i];
        end_mux  = end_mux | req_tx_end[i];
        data_mux = data_mux | req_tx_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign g_req       = |(req_tx_req & grant_q);
  assign g_end       = |(req_tx_end & grant_q);
  assign busy        = (state_q == REQ) || (state_q == XMIT);
  assign timeout_hit = (state_q == XMIT) && !g_end && (timer_q == TW'(TIMEOUT - 1));

  assign tx_req      = (state_q == REQ) && g_req;
  assign req_tx_rdy  = busy ? (grant_q & {NUM_REQ{tx_rdy}}) : '0;
  assign tx_st       = st_mux;
  assign tx_end      = end_mux;
  assign tx_data     = data_mux;
  assign grant       = grant_q;
  assign pkt_timeout = timeout_hit;

  always_ff @(posedge clk_125 or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      last_q  <= IDX_W'(NUM_REQ - 1);
      timer_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|req_tx_req) begin
            grant_q <= win;
            gidx_q  <= win_idx;
            state_q <= REQ;
          end
        end
        REQ: begin
          if (!g_req) begin
            grant_q <= '0;
            state_q <= IDLE;
          end else if (tx_rdy) begin
            timer_q <= '0;
            state_q <= XMIT;
          end
        end
        XMIT: begin
          // A timed-out packet is dropped without a synthesised tx_end.
          if (g_end || timeout_hit) begin
            last_q  <= gidx_q;
            grant_q <= '0;
            timer_q <= '0;
            state_q <= IDLE;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        default: begin
          grant_q <= '0;
          timer_q <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pcie_tx_arbiter.sv
// tb/tb_pcie_tx_arbiter.sv - self-checking bench for pcie_tx_arbiter
module tb_pcie_tx_arbiter;

  logic        clk_125;
  logic        rstn;
  logic [1:0]  req_tx_req;
  logic [1:0]  req_tx_rdy;
  logic [1:0]  req_tx_st;
  logic [1:0]  req_tx_end;
  logic [31:0] req_tx_data;
  logic        tx_req;
  logic        tx_rdy;
  logic        tx_st;
  logic        tx_end;
  logic [15:0] tx_data;
  logic [1:0]  grant;
  logic        pkt_timeout;

  int checks = 0;
  int errors = 0;

  pcie_tx_arbiter #(.NUM_REQ(2), .TIMEOUT(1024)) dut (
    .clk_125     (clk_125),
    .rstn        (rstn),
    .req_tx_req  (req_tx_req),
    .req_tx_rdy  (req_tx_rdy),
    .req_tx_st   (req_tx_st),
    .req_tx_end  (req_tx_end),
    .req_tx_data (req_tx_data),
    .tx_req      (tx_req),
    .tx_rdy      (tx_rdy),
    .tx_st       (tx_st),
    .tx_end      (tx_end),
    .tx_data     (tx_data),
    .grant       (grant),
    .pkt_timeout (pkt_timeout)
  );

  initial clk_125 = 1'b0;
  always #4 clk_125 = ~clk_125;

  typedef struct {
    logic        rstn;
    logic [1:0]  req;
    logic [1:0]  st;
    logic [1:0]  en;
    logic [15:0] d0;
    logic [15:0] d1;
    logic        rdy;
    logic        e_txreq;
    logic [1:0]  e_rrdy;
    logic        e_st;
    logic        e_end;
    logic [15:0] e_data;
    logic [1:0]  e_grant;
    logic        e_to;
  } vec_t;

  vec_t tbl[23];
  vec_t exp_q[$];
  logic [15:0] exp_data_q[$];
  int exp_g_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic [1:0] rq, input logic [1:0] st,
                              input logic [1:0] en, input logic [15:0] d0, input logic [15:0] d1,
                              input logic rdy, input logic etr, input logic [1:0] err,
                              input logic est, input logic een, input logic [15:0] ed,
                              input logic [1:0] eg, input logic eto);
    vec_t v;
    v.rstn = r; v.req = rq; v.st = st; v.en = en; v.d0 = d0; v.d1 = d1; v.rdy = rdy;
    v.e_txreq = etr; v.e_rrdy = err; v.e_st = est; v.e_end = een; v.e_data = ed;
    v.e_grant = eg; v.e_to = eto;
    return v;
  endfunction

  task automatic idle_inputs();
    req_tx_req  = '0;
    req_tx_st   = '0;
    req_tx_end  = '0;
    req_tx_data = '0;
    tx_rdy      = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk_125); #1;
    rstn = 1'b0;
    idle_inputs();
    @(posedge clk_125); #1;
    rstn = 1'b1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int    pkts[2];
    int    ph[2];
    int    w[2];
    int    pno[2];
    logic [1:0]  prev_g;
    logic [15:0] word;
    logic        done;
    vec_t  e;

    // rstn rq  st  en  d0       d1       rdy | txreq rrdy st end data     grant to
    tbl[0]  = mk(1, 2'b01, 2'b00, 2'b00, 16'h0000, 16'h0000, 0, 0, 2'b00, 0, 0, 16'h0000, 2'b00, 0);
    tbl[1]  = mk(1, 2'b01, 2'b00, 2'b00, 16'h0000, 16'h0000, 0, 1, 2'b00, 0, 0, 16'h0000, 2'b01, 0);
    tbl[2]  = mk(1, 2'b01, 2'b00, 2'b00, 16'h0000, 16'h0000, 0, 1, 2'b00, 0, 0, 16'h0000, 2'b01, 0);
    tbl[3]  = mk(1, 2'b01, 2'b00, 2'b00, 16'h0000, 16'h0000, 1, 1, 2'b01, 0, 0, 16'h0000, 2'b01, 0);
    tbl[4]  = mk(1, 2'b00, 2'b11, 2'b00, 16'hA001, 16'hBEEF, 1, 0, 2'b01, 1, 0, 16'hA001, 2'b01, 0);
    tbl[5]  = mk(1, 2'b00, 2'b10, 2'b00, 16'hA002, 16'hBEEF, 1, 0, 2'b01, 0, 0, 16'hA002, 2'b01, 0);
    tbl[6]  = mk(1, 2'b00, 2'b00, 2'b10, 16'hA003, 16'hBEEF, 1, 0, 2'b01, 0, 0, 16'hA003, 2'b01, 0);
    tbl[7]  = mk(1, 2'b00, 2'b00, 2'b01, 16'hA004, 16'hBEEF, 1, 0, 2'b01, 0, 1, 16'hA004, 2'b01, 0);
    tbl[8]  = mk(1, 2'b00, 2'b00, 2'b00, 16'h0000, 16'h0000, 1, 0, 2'b00, 0, 0, 16'h0000, 2'b00, 0);
    tbl[9]  = mk(1, 2'b10, 2'b00, 2'b00, 16'h0000, 16'h0000, 0, 0, 2'b00, 0, 0, 16'h0000, 2'b00, 0);
    tbl[10] = mk(1, 2'b11, 2'b00, 2'b00, 16'h0000, 16'h0000, 0, 1, 2'b00, 0, 0, 16'h0000, 2'b10, 0);
    tbl[11] = mk(1, 2'b01, 2'b00, 2'b00, 16'h0000, 16'h0000, 0, 0, 2'b00, 0, 0, 16'h0000, 2'b10, 0);
    tbl[12] = mk(1, 2'b01, 2'b00, 2'b00, 16'h0000, 16'h0000, 1, 0, 2'b00, 0, 0, 16'h0000, 2'b00, 0);
    tbl[13] = mk(1, 2'b01, 2'b00, 2'b00, 16'h0000, 16'h0000, 1, 1, 2'b01, 0, 0, 16'h0000, 2'b01, 0);
    tbl[14] = mk(1, 2'b00, 2'b01, 2'b00, 16'hC001, 16'h0000, 1, 0, 2'b01, 1, 0, 16'hC001, 2'b01, 0);
    tbl[15] = mk(0, 2'b00, 2'b00, 2'b00, 16'hC002, 16'h0000, 1, 0, 2'b00, 0, 0, 16'h0000, 2'b00, 0);
    tbl[16] = mk(0, 2'b11, 2'b00, 2'b00, 16'h0000, 16'h0000, 1, 0, 2'b00, 0, 0, 16'h0000, 2'b00, 0);
    tbl[17] = mk(1, 2'b11, 2'b00, 2'b00, 16'h0000, 16'h0000, 0, 0, 2'b00, 0, 0, 16'h0000, 2'b00, 0);
    tbl[18] = mk(1, 2'b11, 2'b00, 2'b00, 16'h0000, 16'h0000, 0, 1, 2'b00, 0, 0, 16'h0000, 2'b01, 0);
    tbl[19] = mk(1, 2'b11, 2'b00, 2'b00, 16'h0000, 16'h0000, 1, 1, 2'b01, 0, 0, 16'h0000, 2'b01, 0);
    tbl[20] = mk(1, 2'b10, 2'b01, 2'b01, 16'hC0DE, 16'h0000, 1, 0, 2'b01, 1, 1, 16'hC0DE, 2'b01, 0);
    tbl[21] = mk(1, 2'b10, 2'b00, 2'b00, 16'h0000, 16'h0000, 1, 0, 2'b00, 0, 0, 16'h0000, 2'b00, 0);
    tbl[22] = mk(1, 2'b10, 2'b00, 2'b00, 16'h0000, 16'h0000, 1, 1, 2'b10, 0, 0, 16'h0000, 2'b10, 0);

    rstn = 1'b0;
    idle_inputs();
    repeat (3) @(posedge clk_125);
    #3;
    chk("rst_tx_req", 32'(tx_req), 32'd0);
    chk("rst_req_tx_rdy", 32'(req_tx_rdy), 32'd0);
    chk("rst_tx_st", 32'(tx_st), 32'd0);
    chk("rst_tx_end", 32'(tx_end), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_pkt_timeout", 32'(pkt_timeout), 32'd0);
    @(posedge clk_125); #1;
    rstn = 1'b1;

    for (int i = 0; i < 23; i++) begin
      @(posedge clk_125); #1;
      rstn        = tbl[i].rstn;
      req_tx_req  = tbl[i].req;
      req_tx_st   = tbl[i].st;
      req_tx_end  = tbl[i].en;
      req_tx_data = {tbl[i].d1, tbl[i].d0};
      tx_rdy      = tbl[i].rdy;
      exp_q.push_back(tbl[i]);
      #2;
      e = exp_q.pop_front();
      chk($sformatf("r%0d_tx_req", i), 32'(tx_req), 32'(e.e_txreq));
      chk($sformatf("r%0d_req_tx_rdy", i), 32'(req_tx_rdy), 32'(e.e_rrdy));
      chk($sformatf("r%0d_tx_st", i), 32'(tx_st), 32'(e.e_st));
      chk($sformatf("r%0d_tx_end", i), 32'(tx_end), 32'(e.e_end));
      chk($sformatf("r%0d_tx_data", i), 32'(tx_data), 32'(e.e_data));
      chk($sformatf("r%0d_grant", i), 32'(grant), 32'(e.e_grant));
      chk($sformatf("r%0d_pkt_timeout", i), 32'(pkt_timeout), 32'(e.e_to));
    end

    // Two requesters each sending two 4-word TLPs must strictly alternate 0,1,0,1.
    do_reset();
    for (int i = 0; i < 2; i++) begin
      pkts[i] = 2; ph[i] = 0; w[i] = 0; pno[i] = 0;
    end
    exp_g_q.push_back(0); exp_g_q.push_back(1);
    exp_g_q.push_back(0); exp_g_q.push_back(1);
    prev_g = '0;
    done = 1'b0;
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      @(posedge clk_125); #1;
      idle_inputs();
      tx_rdy = 1'b1;
      for (int i = 0; i < 2; i++) begin
        case (ph[i])
          0: if (pkts[i] > 0) begin req_tx_req[i] = 1'b1; ph[i] = 1; end
          1: req_tx_req[i] = 1'b1;
          default: begin
            word = 16'((i + 1) * 4096 + pno[i] * 256 + w[i]);
            req_tx_st[i]  = (w[i] == 0);
            req_tx_end[i] = (w[i] == 3);
            req_tx_data[i*16 +: 16] = word;
            exp_data_q.push_back(word);
            w[i]++;
            if (w[i] == 4) begin ph[i] = 0; pkts[i]--; pno[i]++; end
          end
        endcase
      end
      #2;
      if (exp_data_q.size() > 0) chk("alt_tx_data", 32'(tx_data), 32'(exp_data_q.pop_front()));
      if (grant != 2'b00 && prev_g == 2'b00) begin
        if (exp_g_q.size() == 0) chk("alt_extra_grant", 32'(grant), 32'd0);
        else chk("alt_grant", 32'(grant), 32'(2'b01 << exp_g_q.pop_front()));
      end
      for (int i = 0; i < 2; i++) begin
        if (ph[i] == 1 && req_tx_rdy[i] && tx_req) begin ph[i] = 2; w[i] = 0; end
      end
      prev_g = grant;
      if (pkts[0] == 0 && pkts[1] == 0 && ph[0] == 0 && ph[1] == 0) done = 1'b1;
    end
    chk("alt_done", 32'(done), 32'd1);
    chk("alt_grants_left", 32'(exp_g_q.size()), 32'd0);

    // Requester 0 never ends its TLP; requester 1 keeps requesting.
    do_reset();
    @(posedge clk_125); #1;
    req_tx_req = 2'b11;
    tx_rdy = 1'b1;
    @(posedge clk_125); #1;
    #2;
    chk("to_tx_req", 32'(tx_req), 32'd1);
    for (int k = 0; k < 1024; k++) begin
      @(posedge clk_125); #1;
      req_tx_req = 2'b10;
      req_tx_st = (k == 0) ? 2'b01 : 2'b00;
      req_tx_data = {16'h0000, 16'(k)};
      #2;
      chk($sformatf("to_pulse_k%0d", k), 32'(pkt_timeout), 32'(k == 1023));
      if (k == 1023) chk("to_no_tx_end", 32'(tx_end), 32'd0);
    end
    @(posedge clk_125); #1;
    req_tx_st = '0;
    #2;
    chk("to_idle_grant", 32'(grant), 32'd0);
    chk("to_idle_pulse", 32'(pkt_timeout), 32'd0);
    @(posedge clk_125); #1;
    #2;
    chk("to_next_grant", 32'(grant), 32'b10);
    chk("to_next_tx_req", 32'(tx_req), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
